// File: rtl/clock_set_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : clock_pkg
// Brief   : Shared state/field encodings and time-range limits for the clock.
// Rev     : 1.0
// ============================================================================
package clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EDIT_H = 3'd1,
        ST_EDIT_M = 3'd2,
        ST_EDIT_S = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HRS  = 2'd1,
        FIELD_MIN  = 2'd2,
        FIELD_SEC  = 2'd3
    } field_t;

    localparam logic [5:0] HRS24_MAX  = 6'd23;
    localparam logic [5:0] HRS12_MIN  = 6'd1;
    localparam logic [5:0] HRS12_MAX  = 6'd12;
    localparam logic [5:0] MINSEC_MAX = 6'd59;

    // Midnight has no 0 in 12 h notation; it is shown as 12.
    function automatic logic [5:0] entry_hrs(input logic fmt_12h, input logic [5:0] hrs);
        return (fmt_12h && (hrs == 6'd0)) ? HRS12_MAX : hrs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_set_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : clock_set_ctrl_if
// Brief     : Time-load bundle from the set controller to the digital clocks.
// Rev       : 1.0
// ============================================================================
interface clock_set_ctrl_if;

    logic       set_time_o;
    logic [5:0] set_hrs_o;
    logic [5:0] set_min_o;
    logic [5:0] set_sec_o;

    modport master (output set_time_o, set_hrs_o, set_min_o, set_sec_o);
    modport slave  (input  set_time_o, set_hrs_o, set_min_o, set_sec_o);

endinterface
`default_nettype wire

// File: rtl/clock_set_ctrl_wrap_step.sv
`default_nettype none
// ============================================================================
// Module : wrap_step
// Brief  : Combinational +/-1 with wrap inside a run-time [min, max] range.
// Rev    : 1.0
// ============================================================================
module wrap_step #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [WIDTH-1:0] i_min,
    input  logic [WIDTH-1:0] i_max,
    input  logic             i_up,
    input  logic             i_down,
    output logic [WIDTH-1:0] o_value
);

    always_comb begin
        o_value = i_value;
        if (i_up) begin
            o_value = (i_value >= i_max) ? i_min : i_value + 1'b1;
        end else if (i_down) begin
            o_value = (i_value <= i_min) ? i_max : i_value - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module : clock_set_ctrl
// Brief  : Three-button hh:mm:ss editor with auto-repeat, timeout and blink.
// Rev    : 1.0
// ============================================================================
module clock_set_ctrl #(
    parameter int HOLD_TICKS    = 500,
    parameter int REPEAT_TICKS  = 100,
    parameter int TIMEOUT_TICKS = 30000,
    parameter int BLINK_TICKS   = 250
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    tick_1khz_i,
    input  logic                    btn_set_i,
    input  logic                    btn_up_i,
    input  logic                    btn_down_i,
    input  logic                    fmt_12h_i,
    input  logic [5:0]              cur_hrs_i,
    input  logic [5:0]              cur_min_i,
    input  logic [5:0]              cur_sec_i,
    clock_set_ctrl_if.master        set_bus,
    output logic                    edit_o,
    output logic [1:0]              field_o,
    output logic                    blink_o
);

    import clock_pkg::*;

    localparam int HOLD_W  = $clog2(HOLD_TICKS + REPEAT_TICKS);
    localparam int TO_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

    localparam logic [HOLD_W-1:0]  c_hold_last   = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [HOLD_W-1:0]  c_hold_reload = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0]  c_rep_last    = HOLD_W'(HOLD_TICKS + REPEAT_TICKS - 1);
    localparam logic [TO_W-1:0]    c_to_last     = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [BLINK_W-1:0] c_blink_last  = BLINK_W'(BLINK_TICKS - 1);

    state_t              r_state;
    field_t              r_field;
    logic                r_edit;
    logic                r_blink;
    logic                r_set_time;
    logic [5:0]          r_hrs;
    logic [5:0]          r_min;
    logic [5:0]          r_sec;
    logic                r_set_q;
    logic                r_up_q;
    logic                r_down_q;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [BLINK_W-1:0]  r_blink_cnt;

    logic                w_set_rise;
    logic                w_up_rise;
    logic                w_dn_rise;
    logic                w_any_edge;
    logic                w_one_held;
    logic                w_rep_fire;
    logic                w_timeout;
    logic                w_blink_toggle;
    logic                w_gate;
    logic                w_step_up;
    logic                w_step_dn;
    logic                w_hrs_bad;
    logic [5:0]          w_cur_val;
    logic [5:0]          w_min_val;
    logic [5:0]          w_max_val;
    logic [5:0]          w_next_val;

    // Previous levels reset high so a button held through reset is not an edge.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_set_q  <= 1'b1;
            r_up_q   <= 1'b1;
            r_down_q <= 1'b1;
        end else begin
            r_set_q  <= btn_set_i;
            r_up_q   <= btn_up_i;
            r_down_q <= btn_down_i;
        end
    end

    assign w_set_rise = btn_set_i  & ~r_set_q;
    assign w_up_rise  = btn_up_i   & ~r_up_q;
    assign w_dn_rise  = btn_down_i & ~r_down_q;
    assign w_any_edge = (btn_set_i ^ r_set_q) | (btn_up_i ^ r_up_q) | (btn_down_i ^ r_down_q);
    assign w_one_held = btn_up_i ^ btn_down_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_hold_cnt <= '0;
        end else if (!r_edit || !w_one_held || w_up_rise || w_dn_rise) begin
            r_hold_cnt <= '0;
        end else if (tick_1khz_i) begin
            r_hold_cnt <= (r_hold_cnt == c_rep_last) ? c_hold_reload : r_hold_cnt + 1'b1;
        end
    end

    assign w_rep_fire = r_edit & w_one_held & tick_1khz_i & ~w_up_rise & ~w_dn_rise &
                        ((r_hold_cnt == c_hold_last) | (r_hold_cnt == c_rep_last));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_to_cnt <= '0;
        end else if (!r_edit || w_any_edge) begin
            r_to_cnt <= '0;
        end else if (tick_1khz_i) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = r_edit & tick_1khz_i & ~w_any_edge & (r_to_cnt == c_to_last);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_blink_cnt <= '0;
        end else if (!r_edit) begin
            r_blink_cnt <= '0;
        end else if (tick_1khz_i) begin
            r_blink_cnt <= (r_blink_cnt == c_blink_last) ? '0 : r_blink_cnt + 1'b1;
        end
    end

    assign w_blink_toggle = r_edit & tick_1khz_i & (r_blink_cnt == c_blink_last);

    // Set has priority: a step arriving with a set edge is dropped.
    assign w_gate    = r_edit & ~w_set_rise & ~w_timeout;
    assign w_step_up = w_gate & ((w_up_rise & ~btn_down_i) | (w_rep_fire & btn_up_i));
    assign w_step_dn = w_gate & ((w_dn_rise & ~btn_up_i)   | (w_rep_fire & btn_down_i));
    assign w_hrs_bad = fmt_12h_i & ((r_hrs == 6'd0) | (r_hrs > HRS12_MAX));

    always_comb begin
        w_cur_val = r_sec;
        w_min_val = 6'd0;
        w_max_val = MINSEC_MAX;
        case (r_state)
            ST_EDIT_H: begin
                w_cur_val = r_hrs;
                w_min_val = fmt_12h_i ? HRS12_MIN : 6'd0;
                w_max_val = fmt_12h_i ? HRS12_MAX : HRS24_MAX;
            end
            ST_EDIT_M: w_cur_val = r_min;
            default:   w_cur_val = r_sec;
        endcase
    end

    wrap_step #(
        .WIDTH (6)
    ) u_step (
        .i_value (w_cur_val),
        .i_min   (w_min_val),
        .i_max   (w_max_val),
        .i_up    (w_step_up),
        .i_down  (w_step_dn),
        .o_value (w_next_val)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= ST_IDLE;
            r_field    <= FIELD_NONE;
            r_edit     <= 1'b0;
            r_blink    <= 1'b0;
            r_set_time <= 1'b0;
            r_hrs      <= '0;
            r_min      <= '0;
            r_sec      <= '0;
        end else begin
            r_set_time <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_set_rise) begin
                        r_state <= ST_EDIT_H;
                        r_field <= FIELD_HRS;
                        r_edit  <= 1'b1;
                        r_blink <= 1'b1;
                        r_hrs   <= entry_hrs(fmt_12h_i, cur_hrs_i);
                        r_min   <= cur_min_i;
                        r_sec   <= cur_sec_i;
                    end
                end
                ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                    if (w_blink_toggle) begin
                        r_blink <= ~r_blink;
                    end
                    if (w_step_up || w_step_dn) begin
                        case (r_state)
                            ST_EDIT_H: r_hrs <= w_next_val;
                            ST_EDIT_M: r_min <= w_next_val;
                            default:   r_sec <= w_next_val;
                        endcase
                    end
                    // A switch to 12 h mid-edit pulls illegal hours back into range.
                    if (w_hrs_bad) begin
                        r_hrs <= HRS12_MAX;
                    end
                    if (w_set_rise) begin
                        case (r_state)
                            ST_EDIT_H: begin
                                r_state <= ST_EDIT_M;
                                r_field <= FIELD_MIN;
                            end
                            ST_EDIT_M: begin
                                r_state <= ST_EDIT_S;
                                r_field <= FIELD_SEC;
                            end
                            default: begin
                                r_state    <= ST_COMMIT;
                                r_field    <= FIELD_NONE;
                                r_edit     <= 1'b0;
                                r_blink    <= 1'b0;
                                r_set_time <= 1'b1;
                            end
                        endcase
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_field <= FIELD_NONE;
                        r_edit  <= 1'b0;
                        r_blink <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_field <= FIELD_NONE;
                    r_edit  <= 1'b0;
                    r_blink <= 1'b0;
                end
            endcase
        end
    end

    assign set_bus.set_time_o = r_set_time;
    assign set_bus.set_hrs_o  = r_hrs;
    assign set_bus.set_min_o  = r_min;
    assign set_bus.set_sec_o  = r_sec;
    assign edit_o             = r_edit;
    assign field_o            = r_field;
    assign blink_o            = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_clock_set_ctrl
// Brief  : Directed self-checking bench for the clock time-set controller.
// Rev    : 1.0
// ============================================================================
module tb_clock_set_ctrl;

    localparam int B_SET  = 0;
    localparam int B_UP   = 1;
    localparam int B_DOWN = 2;

    logic       clk      = 1'b0;
    logic       reset_i  = 1'b0;
    logic       tick     = 1'b0;
    logic       btn_set  = 1'b0;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic       fmt_12h  = 1'b0;
    logic [5:0] cur_hrs  = 6'd0;
    logic [5:0] cur_min  = 6'd0;
    logic [5:0] cur_sec  = 6'd0;
    logic       edit;
    logic [1:0] field;
    logic       blink;

    int checks   = 0;
    int failures = 0;
    int st_seen  = 0;
    int st_mark  = 0;

    clock_set_ctrl_if set_bus ();

    clock_set_ctrl dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .tick_1khz_i (tick),
        .btn_set_i   (btn_set),
        .btn_up_i    (btn_up),
        .btn_down_i  (btn_down),
        .fmt_12h_i   (fmt_12h),
        .cur_hrs_i   (cur_hrs),
        .cur_min_i   (cur_min),
        .cur_sec_i   (cur_sec),
        .set_bus     (set_bus),
        .edit_o      (edit),
        .field_o     (field),
        .blink_o     (blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (set_bus.set_time_o === 1'b1) st_seen++;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            B_SET:   btn_set  = v;
            B_UP:    btn_up   = v;
            default: btn_down = v;
        endcase
    endtask

    task automatic pulse(input int which, input int n);
        repeat (n) begin
            set_btn(which, 1'b1);
            cyc();
            set_btn(which, 1'b0);
            cyc();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        // Reset state
        cur_hrs = 6'd11; cur_min = 6'd35; cur_sec = 6'd42;
        cyc(3);
        chk("rst_set_time", 32'(set_bus.set_time_o), 0);
        chk("rst_hrs",      32'(set_bus.set_hrs_o), 0);
        chk("rst_edit",     32'(edit), 0);
        chk("rst_field",    32'(field), 0);
        chk("rst_blink",    32'(blink), 0);
        reset_i = 1'b1;
        cyc(2);

        // 24 h edit of 11:35:42 -> 00:59:42
        pulse(B_SET, 1);
        chk("entry_edit",  32'(edit), 1);
        chk("entry_field", 32'(field), 1);
        chk("entry_hrs",   32'(set_bus.set_hrs_o), 11);
        chk("entry_min",   32'(set_bus.set_min_o), 35);
        chk("entry_sec",   32'(set_bus.set_sec_o), 42);
        chk("entry_blink", 32'(blink), 1);
        pulse(B_UP, 13);
        chk("hrs24_wrap", 32'(set_bus.set_hrs_o), 0);
        pulse(B_SET, 1);
        chk("field_min", 32'(field), 2);
        pulse(B_DOWN, 36);
        chk("min_wrap_down", 32'(set_bus.set_min_o), 59);
        pulse(B_SET, 1);
        chk("field_sec", 32'(field), 3);
        btn_set = 1'b1;
        cyc();
        chk("commit_strobe", 32'(set_bus.set_time_o), 1);
        chk("commit_hrs",    32'(set_bus.set_hrs_o), 0);
        chk("commit_min",    32'(set_bus.set_min_o), 59);
        chk("commit_sec",    32'(set_bus.set_sec_o), 42);
        chk("commit_edit",   32'(edit), 0);
        chk("commit_field",  32'(field), 0);
        btn_set = 1'b0;
        cyc();
        chk("strobe_one_cycle", 32'(set_bus.set_time_o), 0);
        chk("hold_min_after",   32'(set_bus.set_min_o), 59);

        // 12 h wrap and clamp
        fmt_12h = 1'b1; cur_hrs = 6'd12; cur_min = 6'd0; cur_sec = 6'd0;
        pulse(B_SET, 1);
        chk("h12_entry", 32'(set_bus.set_hrs_o), 12);
        pulse(B_UP, 1);
        chk("h12_up_wrap", 32'(set_bus.set_hrs_o), 1);
        pulse(B_DOWN, 1);
        chk("h12_down_wrap", 32'(set_bus.set_hrs_o), 12);
        fmt_12h = 1'b0;
        pulse(B_UP, 1);
        chk("h24_up_13", 32'(set_bus.set_hrs_o), 13);
        fmt_12h = 1'b1;
        cyc();
        chk("h12_clamp", 32'(set_bus.set_hrs_o), 12);
        pulse(B_SET, 2);
        chk("field_sec_12h", 32'(field), 3);
        pulse(B_DOWN, 2);
        chk("sec_58", 32'(set_bus.set_sec_o), 58);

        // Auto-repeat from 58
        btn_up = 1'b1;
        cyc();
        chk("rep_press", 32'(set_bus.set_sec_o), 59);
        ticks(499);
        chk("rep_t499", 32'(set_bus.set_sec_o), 59);
        ticks(1);
        chk("rep_t500", 32'(set_bus.set_sec_o), 0);
        ticks(99);
        chk("rep_t599", 32'(set_bus.set_sec_o), 0);
        ticks(1);
        chk("rep_t600", 32'(set_bus.set_sec_o), 1);
        ticks(100);
        chk("rep_t700", 32'(set_bus.set_sec_o), 2);
        btn_up = 1'b0;
        cyc();
        chk("rep_release", 32'(set_bus.set_sec_o), 2);

        // Up and down together
        btn_up = 1'b1; btn_down = 1'b1;
        cyc();
        chk("both_press", 32'(set_bus.set_sec_o), 2);
        ticks(1000);
        chk("both_held", 32'(set_bus.set_sec_o), 2);
        btn_up = 1'b0; btn_down = 1'b0;
        cyc();

        // Set + up together: set wins
        btn_set = 1'b1; btn_up = 1'b1;
        cyc();
        chk("setup_strobe", 32'(set_bus.set_time_o), 1);
        chk("setup_sec",    32'(set_bus.set_sec_o), 2);
        chk("setup_hrs",    32'(set_bus.set_hrs_o), 12);
        chk("setup_field",  32'(field), 0);
        btn_set = 1'b0; btn_up = 1'b0;
        cyc();

        // Blink and inactivity timeout; 12 h entry from hour 0
        cur_hrs = 6'd0; cur_min = 6'd6; cur_sec = 6'd7;
        pulse(B_SET, 1);
        chk("h12_zero_entry", 32'(set_bus.set_hrs_o), 12);
        st_mark = st_seen;
        ticks(249);
        chk("blink_t249", 32'(blink), 1);
        ticks(1);
        chk("blink_t250", 32'(blink), 0);
        ticks(29749);
        chk("to_t29999_edit", 32'(edit), 1);
        ticks(1);
        chk("to_edit",    32'(edit), 0);
        chk("to_field",   32'(field), 0);
        chk("to_blink",   32'(blink), 0);
        chk("to_hold_min", 32'(set_bus.set_min_o), 6);
        chk("to_no_strobe", 32'(st_seen), 32'(st_mark));

        // Reset mid-edit with buttons held through release
        fmt_12h = 1'b0; cur_hrs = 6'd5; cur_min = 6'd10; cur_sec = 6'd20;
        pulse(B_SET, 2);
        chk("pre_rst_field", 32'(field), 2);
        btn_set = 1'b1; btn_up = 1'b1;
        reset_i = 1'b0;
        cyc();
        chk("mid_rst_edit",  32'(edit), 0);
        chk("mid_rst_field", 32'(field), 0);
        chk("mid_rst_min",   32'(set_bus.set_min_o), 0);
        chk("mid_rst_blink", 32'(blink), 0);
        reset_i = 1'b1;
        cyc(3);
        chk("held_set_no_edge", 32'(edit), 0);
        btn_set = 1'b0;
        cyc();
        pulse(B_SET, 1);
        cyc(2);
        chk("held_up_no_step", 32'(set_bus.set_hrs_o), 5);
        btn_up = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-set controller for the multi-mode clock top. It turns three debounced push-buttons into a field-by-field hours/minutes/seconds edit sequence with auto-repeat and an inactivity timeout. On commit it drives the `set_time`/`set_hrs`/`set_min`/`set_sec` bundle consumed by the 12 h and 24 h digital clocks. It also gives the VGA display path a field-select and blink indication.

## Interface
Parameters:
- HOLD_TICKS, 500: 1 kHz ticks a held up/down button must stay pressed before auto-repeat starts.
- REPEAT_TICKS, 100: ticks between auto-repeat steps.
- TIMEOUT_TICKS, 30000: ticks without any button edge before an edit is aborted.
- BLINK_TICKS, 250: half-period of blink_o.

Ports:
- clk_i, in, 1: system clock.
- reset_i, in, 1: asynchronous, active-low reset.
- tick_1khz_i, in, 1: one-cycle strobe at 1 kHz, synchronous to clk_i.
- btn_set_i / btn_up_i / btn_down_i, in, 1 each: debounced, synchronous button levels.
- fmt_12h_i, in, 1: 1 selects 12 h hour range (1..12); 0 selects 0..23.
- cur_hrs_i, in, 6; cur_min_i, in, 6; cur_sec_i, in, 6: live time, sampled on edit entry.
- set_time_o, out, 1: one-cycle load strobe.
- set_hrs_o, out, 6; set_min_o, out, 6; set_sec_o, out, 6: edit values, valid while set_time_o=1.
- edit_o, out, 1: high in any edit state.
- field_o, out, 2: 0 none, 1 hrs, 2 min, 3 sec.
- blink_o, out, 1: toggles every BLINK_TICKS ticks while edit_o=1; 0 otherwise.

## Operation
- Edge detection: a registered previous level is kept per button and resets to 1, so a button held through reset produces no edge. Only rising edges act, except for auto-repeat.
- FSM states: IDLE → EDIT_H → EDIT_M → EDIT_S → COMMIT → IDLE.
- IDLE: set edge → EDIT_H, and cur_*_i are loaded into set_*_o. If fmt_12h_i=1 and cur_hrs_i=0, hours load as 12.
- EDIT_x: set edge advances to the next state. EDIT_S + set edge → COMMIT.
- COMMIT: lasts one cycle, asserts set_time_o, then returns to IDLE.
- Up/down step the current field by ±1 with wrap:
  - hours 0..23, or 1..12 in 12 h mode;
  - min/sec 0..59;
  - e.g. 59+1→0, 0−1→59, 12+1→1 (12 h), 1−1→12 (12 h).
- A fmt_12h_i change mid-edit: out-of-range hours (0 or >12 in 12 h) are clamped to 12 on the next cycle.
- Auto-repeat:
  - A hold counter counts ticks while exactly one of up/down is high.
  - At HOLD_TICKS the block issues a step, then issues one step every REPEAT_TICKS while the button stays held.
  - The counter clears on release.
- Simultaneous events:
  - up and down together: no step, hold counter cleared.
  - set together with up/down: set wins, the step is dropped.
- Timeout: a tick counter clears on any button edge. Reaching TIMEOUT_TICKS in EDIT_x → IDLE with no set_time_o; set_*_o hold their values.
- Reset, at any time including mid-edit:
  - state IDLE;
  - set_time_o=0, set_*_o=0, edit_o=0, field_o=0, blink_o=0;
  - all counters 0.

## Timing
- Button edge to field update, state change and field_o: 1 cycle, so the registered output is visible on the cycle after the edge cycle.
- set_time_o is high for exactly one clk_i cycle, the cycle after the final set edge. set_*_o are stable from that cycle onward.
- The first repeat step happens on the HOLD_TICKS-th tick_1khz_i after the press edge. The press edge itself steps once.
- edit_o and field_o change in the same cycle as the state register.
- blink_o starts at 1 on edit entry.

## Structure
- Shared package `clock_pkg`: FSM state enum, field_o encoding, range constants HRS24_MAX=23, HRS12_MIN=1, HRS12_MAX=12, MINSEC_MAX=59.
- Sub-module `wrap_step`: combinational ±1 with a parameterised min/max. Instantiated once, with the range muxed by field.
- Edge detect, hold/repeat counter, timeout counter and blink counter stay in the top.

## Test plan
- Reset mid-edit (EDIT_M) → all outputs 0, state IDLE; a button held through reset release produces no edge.
- cur=11:35:42, 24 h; set, up×13, set, down×36, set, set → set_time_o one cycle with 00:59:42.
- 12 h mode, hours=12, one up → 1; hours=1, one down → 12; cur_hrs_i=0 on entry loads 12.
- Hold up in EDIT_S from 58 for 700 ticks → steps at press (59), tick 500 (0), tick 600 (1), tick 700 (2).
- Up+down held together for 1000 ticks → no change. Set+up in the same cycle → field advances, value unchanged.
- Enter edit, no presses for 30000 ticks → edit_o falls and set_time_o never asserts.
